regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the register file's single write port between several writeback sources: ALU writeback, load return, and accelerator/MMIO result return. Each source has its own small skid FIFO. A round-robin arbiter grants one write per cycle and drives `write_en`/`rd`/`write_data` from a posedge register, so values are stable when the register file captures on the negedge. A per-register pending mask lets the pipeline stall reads of registers whose writes are still queued.

## Interface
- `NUM_REQ`, 3, number of writeback requesters; index 0 = ALU, 1 = load, 2 = accelerator.
- `ADDR_W`, 5, register index width.
- `DATA_W`, 32, data width.
- `FIFO_DEPTH`, 2, entries per requester FIFO; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_ready`  out  NUM_REQ  per-requester accept; `= !fifo_full[i]`.
- `req_rd`  in  NUM_REQ×ADDR_W  destination register per requester.
- `req_data`  in  NUM_REQ×DATA_W  write data per requester.
- `write_en`  out  1  to register file write enable.
- `rd`  out  ADDR_W  to register file destination.
- `write_data`  out  DATA_W  to register file data.
- `grant_id`  out  $clog2(NUM_REQ)  requester that owns the current `write_en` cycle.
- `pending_mask`  out  2**ADDR_W  bit r = 1 while any queued or in-flight write targets r.

## Operation
- **Handshake.** A request transfers at a posedge where `req_valid[i] & req_ready[i]`.
  - `req_ready` does not depend on `req_valid` and does not look ahead to a same-cycle dequeue. A full FIFO refuses the request even if it is being popped that cycle.
- **x0 filter.** If `req_rd[i] == 0`, the handshake completes but nothing is enqueued and no write is ever issued.
- **FIFO.** Per requester, order-preserving, depth `FIFO_DEPTH`. Simultaneous push and pop on a non-full FIFO is allowed; count is unchanged.
- **Arbiter.**
  - Combinational pick among non-empty FIFOs, searching upward from `last_grant+1` modulo `NUM_REQ`.
  - The picked FIFO head is popped and copied into the output register at the posedge.
  - `last_grant` updates only when a grant is issued.
  - With no FIFO non-empty, `write_en` is 0 the next cycle; `rd`, `write_data` and `grant_id` hold their last values.
- **Ordering.** Writes from the same requester retire in order. No ordering is guaranteed across requesters; same-rd conflicts between requesters are resolved by the issuing pipeline.
- **Pending mask.**
  - Combinational OR of the decoded `rd` of every valid FIFO entry and of the output register while `write_en` = 1.
  - `pending_mask[0]` is always 0.
- **Reset** (`rst` = 1 at a posedge):
  - All FIFOs are emptied and `write_en` goes to 0.
  - `rd`, `write_data` and `grant_id` go to 0; `last_grant` goes to `NUM_REQ-1`, so requester 0 has first priority.
  - `pending_mask` is 0 and `req_ready` is all-ones from the following cycle.
  - Mid-operation reset discards queued writes silently. Requests presented in the reset cycle are not accepted.

## Timing
- **Minimum latency.** A handshake at posedge E0 gives head-valid after E0, grant at E1, and `write_en` high for the cycle E1→E2. The register file captures at the negedge inside that cycle. This is two posedges from accept to write.
- **Throughput.** One write per cycle, sustained while any FIFO is non-empty.
- **Pending mask timing.** A bit sets in the cycle after the accepting edge. It clears in the cycle after the last `write_en` cycle for that rd.
- **Starvation bound.** A non-empty FIFO waits at most `NUM_REQ-1` grants before being served.

## Structure
- Package `regfile_arb_pkg` holds:
  - Constants `NUM_REQ`, `ADDR_W`, `DATA_W`.
  - `typedef struct packed { logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data; } wb_req_t`.
  - A round-robin pick function.
- Sub-module `wb_skid_fifo`, parameterised by depth and element type. It exposes `full`, `empty` and per-entry valid/rd for the pending-mask logic. It is instantiated `NUM_REQ` times.
- Top level holds the arbiter, `last_grant`, the output register and the pending-mask OR tree.

## Test plan
- **Single write.** Req0 rd=5, data=0xDEADBEEF at E0 → `write_en`=1, `rd`=5, `write_data`=0xDEADBEEF, `grant_id`=0 during E1→E2. `pending_mask[5]`=1 during E0→E2 and 0 after.
- **Simultaneous requests.** All three requesters valid at E0 with rd=1/2/3 → writes rd 1, 2, 3 on three consecutive cycles. Then req1 and req2 held continuously → `grant_id` alternates 1, 2, 1, 2.
- **x0 drop.** Req2 rd=0, data=0x1234 → `req_ready[2]`=1, `write_en` never asserted, `pending_mask` stays 0.
- **Backpressure.** Req0 pushes rd=7, 8, 9 back-to-back while req1/req2 saturate → `req_ready[0]` drops after two accepts. rd=9 is accepted later, and writes arrive in order 7, 8, 9 with no loss.
- **Same-rd conflict.** Req0 and req1 both target rd=10 → `pending_mask[10]` stays 1 until both writes retire, then clears.
- **Reset mid-operation.** Reset one cycle with 4 entries queued → after the edge, `write_en`=0, `pending_mask`=0, `req_ready`=3'b111, and no stale write appears later.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Holds the requester/register geometry, the writeback payload struct and
// the round-robin pick function used by the top-level arbiter.
package regfile_arb_pkg;

  localparam int unsigned NUM_REQ  = 3;   // 0 = ALU, 1 = load, 2 = accelerator
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned GRANT_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic               valid;
    logic [GRANT_W-1:0] idx;
  } rr_pick_t;

  // First requesting index found searching upward from last+1, wrapping.
  function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                       input logic [GRANT_W-1:0] last);
    rr_pick_t           res;
    logic [GRANT_W-1:0] cand;
    res = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GRANT_W'((32'(last) + k) % NUM_REQ);
      if (!res.valid && req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small order-preserving skid FIFO for one writeback requester.
// Ports: clk/rst (sync, active-high), push/din enqueue, pop dequeues head,
// full/empty status, entry_valid/entry_rd expose every slot for the
// pending-mask logic. Storage is a shift register: slot 0 is always the head.
module wb_skid_fifo
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = wb_req_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  T                             din,
  input  logic                         pop,
  output T                             head,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0] entry_rd
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] wr_idx;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[0];
  // On a simultaneous pop the tail slides down one place before the write.
  assign wr_idx  = do_pop ? (count - CNT_W'(1)) : count;

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Shift on pop, then the push write (later assignment wins for its slot).
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (do_pop) mem[i] <= mem[i+1];
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (do_push && (wr_idx == CNT_W'(i))) mem[i] <= din;
    end
  end

  // Per-slot visibility for the pending mask.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_valid[i] = (CNT_W'(i) < count);
      entry_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback
// sources. Each source feeds a skid FIFO; a round-robin arbiter pops one
// head per cycle into a posedge output register (write_en/rd/write_data/
// grant_id) so the register file can capture on the following negedge.
// Ports: clk, rst (sync active-high), req_valid/req_ready/req_rd/req_data
// per requester (flattened), write_en/rd/write_data/grant_id to the
// register file, pending_mask marks registers with writes still queued.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      write_en,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         write_data,
  output logic [GRANT_W-1:0]        grant_id,
  output logic [NUM_REGS-1:0]       pending_mask
);

  logic [NUM_REQ-1:0]                   fifo_full;
  logic [NUM_REQ-1:0]                   fifo_empty;
  logic [NUM_REQ-1:0]                   push;
  logic [NUM_REQ-1:0]                   pop;
  wb_req_t                              req_pkt    [NUM_REQ];
  wb_req_t                              head       [NUM_REQ];
  logic [FIFO_DEPTH-1:0]                ent_valid  [NUM_REQ];
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]    ent_rd     [NUM_REQ];
  logic [GRANT_W-1:0]                   last_grant;
  rr_pick_t                             pick;

  assign pick = rr_pick(~fifo_empty, last_grant);

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_req
    assign req_pkt[g]   = '{rd:   req_rd[g*ADDR_W +: ADDR_W],
                            data: req_data[g*DATA_W +: DATA_W]};
    assign req_ready[g] = ~fifo_full[g];
    // Writes to x0 complete the handshake but are never queued.
    assign push[g]      = req_valid[g] & ~fifo_full[g] & (req_pkt[g].rd != '0);
    assign pop[g]       = pick.valid & (pick.idx == GRANT_W'(g));

    wb_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (wb_req_t)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push[g]),
      .din         (req_pkt[g]),
      .pop         (pop[g]),
      .head        (head[g]),
      .full        (fifo_full[g]),
      .empty       (fifo_empty[g]),
      .entry_valid (ent_valid[g]),
      .entry_rd    (ent_rd[g])
    );
  end

  // Output register and round-robin pointer; rd/data/grant hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en   <= 1'b0;
      rd         <= '0;
      write_data <= '0;
      grant_id   <= '0;
      last_grant <= GRANT_W'(NUM_REQ - 1);
    end else begin
      write_en <= pick.valid;
      if (pick.valid) begin
        rd         <= head[pick.idx].rd;
        write_data <= head[pick.idx].data;
        grant_id   <= pick.idx;
        last_grant <= pick.idx;
      end
    end
  end

  // OR of every queued destination plus the in-flight write.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      for (int j = 0; j < int'(FIFO_DEPTH); j++) begin
        if (ent_valid[i][j]) pending_mask[ent_rd[i][j]] = 1'b1;
      end
    end
    if (write_en) pending_mask[rd] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule
